// File: rtl/ialu_issue_arbiter.sv
// Round-robin arbiter feeding one IALU execute port through a single registered stage.
// One cycle issue-to-execute; the stage holds under Fu_Ready=0, and kills/flushes free it early.
`ifndef SPEC_STATES
`define SPEC_STATES 4
`endif
`ifndef PORT_S2E_KILLMASK
`define PORT_S2E_KILLMASK 3:0
`endif
`ifndef PORT_S2E_LEN
`define PORT_S2E_LEN 32
`endif

module ialu_issue_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int PAYLOAD_LEN = `PORT_S2E_LEN
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           Flush,
  input  logic                           Kill_Enable,
  input  logic [`SPEC_STATES-1:0]        Kill_VKillMask,
  input  logic                           Resolve_Enable,
  input  logic [`SPEC_STATES-1:0]        Resolve_Mask,
  input  logic [NUM_REQ-1:0]             Req_Valid,
  input  logic [NUM_REQ*PAYLOAD_LEN-1:0] Req_S2E,
  output logic [NUM_REQ-1:0]             Req_Grant,
  input  logic                           Fu_Ready,
  output logic                           Port_Valid,
  output logic [PAYLOAD_LEN-1:0]         Port_S2E,
  output logic                           Busy_Stall
);
  localparam int PW = $clog2(NUM_REQ);

  function automatic logic killed_by(input logic [PAYLOAD_LEN-1:0] p,
                                     input logic en,
                                     input logic [`SPEC_STATES-1:0] vmask);
    return en & (|(p[`PORT_S2E_KILLMASK] & vmask));
  endfunction

  function automatic logic [PAYLOAD_LEN-1:0] clear_resolved(input logic [PAYLOAD_LEN-1:0] p,
                                                            input logic en,
                                                            input logic [`SPEC_STATES-1:0] rmask);
    logic [PAYLOAD_LEN-1:0] r;
    r = p;
    if (en) r[`PORT_S2E_KILLMASK] = p[`PORT_S2E_KILLMASK] & ~rmask;
    return r;
  endfunction

  logic [PW-1:0]          rr_ptr;
  logic [NUM_REQ-1:0]     eligible;
  logic                   held_killed;
  logic                   stage_free;
  logic                   grant_any;
  logic [PW-1:0]          grant_idx;
  logic [PW:0]            scan_idx;
  logic [PAYLOAD_LEN-1:0] grant_payload;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_elig
    assign eligible[i] = Req_Valid[i] & ~Flush & ~rst &
                         ~killed_by(Req_S2E[i*PAYLOAD_LEN +: PAYLOAD_LEN], Kill_Enable, Kill_VKillMask);
  end

  // A held micro-op that is being killed will be dropped anyway, so its slot is free now.
  assign held_killed = killed_by(Port_S2E, Kill_Enable, Kill_VKillMask);
  assign stage_free  = ~Port_Valid | Fu_Ready | held_killed;

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    Req_Grant = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, rr_ptr} + (PW+1)'(k);
      if (scan_idx >= (PW+1)'(NUM_REQ)) scan_idx = scan_idx - (PW+1)'(NUM_REQ);
      if (!grant_any && stage_free && eligible[scan_idx[PW-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = scan_idx[PW-1:0];
      end
    end
    if (grant_any) Req_Grant[grant_idx] = 1'b1;
  end

  assign grant_payload = Req_S2E[int'(grant_idx)*PAYLOAD_LEN +: PAYLOAD_LEN];
  assign Busy_Stall    = (|Req_Valid) & ~grant_any & ~Flush & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      rr_ptr <= (int'(grant_idx) == NUM_REQ-1) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || Flush) begin
      Port_Valid <= 1'b0;
      Port_S2E   <= '0;
    end else if (grant_any) begin
      Port_Valid <= 1'b1;
      Port_S2E   <= clear_resolved(grant_payload, Resolve_Enable, Resolve_Mask);
    end else if (stage_free) begin
      Port_Valid <= 1'b0;
    end else begin
      Port_S2E   <= clear_resolved(Port_S2E, Resolve_Enable, Resolve_Mask);
    end
  end
endmodule

// File: tb/tb_ialu_issue_arbiter.sv
// Directed vector table for the named corner cases, then randomized traffic against a reference model.
`ifndef SPEC_STATES
`define SPEC_STATES 4
`endif
`ifndef PORT_S2E_KILLMASK
`define PORT_S2E_KILLMASK 3:0
`endif
`ifndef PORT_S2E_LEN
`define PORT_S2E_LEN 32
`endif

module tb_ialu_issue_arbiter;
  localparam int N  = 4;
  localparam int PL = 32;

  logic          clk = 1'b0;
  logic          rst, flush, kill_en, res_en, fu_ready;
  logic [3:0]    kill_mask, res_mask, req_valid, req_grant;
  logic [N*PL-1:0] req_s2e;
  logic          port_valid, busy_stall;
  logic [PL-1:0] port_s2e;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ialu_issue_arbiter #(.NUM_REQ(N), .PAYLOAD_LEN(PL)) dut (
    .clk(clk), .rst(rst), .Flush(flush), .Kill_Enable(kill_en), .Kill_VKillMask(kill_mask),
    .Resolve_Enable(res_en), .Resolve_Mask(res_mask), .Req_Valid(req_valid), .Req_S2E(req_s2e),
    .Req_Grant(req_grant), .Fu_Ready(fu_ready), .Port_Valid(port_valid), .Port_S2E(port_s2e),
    .Busy_Stall(busy_stall)
  );

  typedef struct {
    logic r, f, ke, re, fu;
    logic [3:0] km, rm, vld;
    logic [127:0] pay;
    logic [3:0] eg;
    logic eb, epv, cps;
    logic [31:0] eps;
  } vec_t;

  vec_t vecs[27];

  function automatic logic [31:0] pl(input int id, input logic [3:0] km);
    return {28'(id), km};
  endfunction

  function automatic vec_t v(input logic r, f, ke, input logic [3:0] km, input logic re,
                             input logic [3:0] rm, input logic fu, input logic [3:0] vld,
                             input logic [127:0] pay, input logic [3:0] eg, input logic eb,
                             input logic epv, input logic cps, input logic [31:0] eps);
    vec_t t;
    t.r = r; t.f = f; t.ke = ke; t.km = km; t.re = re; t.rm = rm; t.fu = fu; t.vld = vld;
    t.pay = pay; t.eg = eg; t.eb = eb; t.epv = epv; t.cps = cps; t.eps = eps;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, f, ke, input logic [3:0] km, input logic re,
                       input logic [3:0] rm, input logic fu, input logic [3:0] vld,
                       input logic [127:0] pay);
    rst = r; flush = f; kill_en = ke; kill_mask = km; res_en = re; res_mask = rm;
    fu_ready = fu; req_valid = vld; req_s2e = pay;
  endtask

  // Reference model state
  bit          m_valid;
  logic [31:0] m_pay;
  int          m_ptr;

  function automatic bit is_killed(input logic [31:0] p, input logic ke, input logic [3:0] km);
    return ke && ((p[3:0] & km) != 4'd0);
  endfunction

  logic [127:0] D;
  bit          pend[N];
  logic [31:0] ppay[N];

  initial begin
    logic [127:0] pay_all;
    logic [3:0]   vld_all;
    bit           free;
    int           win;
    logic [31:0]  np;
    logic [3:0]   km_r, rm_r;
    logic         ke_r, re_r, fu_r, f_r, r_r;
    logic [3:0]   eg;
    logic         eb;

    D = {pl(4,0), pl(3,0), pl(2,0), pl(1,0)};
    vecs[0]  = v(1,0,0,0,0,0,1,4'b1111,D, 4'b0000,0,0,1,0);
    vecs[1]  = v(1,0,0,0,0,0,1,4'b1111,D, 4'b0000,0,0,1,0);
    vecs[2]  = v(0,0,0,0,0,0,1,4'b1111,D, 4'b0001,0,0,1,0);
    vecs[3]  = v(0,0,0,0,0,0,1,4'b1111,D, 4'b0010,0,1,1,pl(1,0));
    vecs[4]  = v(0,0,0,0,0,0,1,4'b1111,D, 4'b0100,0,1,1,pl(2,0));
    vecs[5]  = v(0,0,0,0,0,0,1,4'b1111,D, 4'b1000,0,1,1,pl(3,0));
    vecs[6]  = v(0,0,0,0,0,0,1,4'b1111,D, 4'b0001,0,1,1,pl(4,0));
    vecs[7]  = v(0,0,0,0,0,0,0,4'b1111,D, 4'b0000,1,1,1,pl(1,0));
    vecs[8]  = v(0,0,0,0,0,0,0,4'b1111,D, 4'b0000,1,1,1,pl(1,0));
    vecs[9]  = v(0,0,0,0,0,0,0,4'b1111,D, 4'b0000,1,1,1,pl(1,0));
    vecs[10] = v(0,0,0,0,0,0,1,4'b1111,D, 4'b0010,0,1,1,pl(1,0));
    vecs[11] = v(0,0,0,0,0,0,1,4'b0100,{pl(4,0),pl(3,2),pl(2,0),pl(1,0)}, 4'b0100,0,1,1,pl(2,0));
    vecs[12] = v(0,0,1,4'b0010,0,0,0,4'b0011,{pl(4,0),pl(3,2),pl(2,0),pl(1,2)}, 4'b0010,0,1,1,pl(3,2));
    vecs[13] = v(0,0,1,4'b0010,0,0,0,4'b0001,{pl(4,0),pl(3,2),pl(2,0),pl(1,2)}, 4'b0000,1,1,1,pl(2,0));
    vecs[14] = v(0,0,1,4'b0010,0,0,1,4'b0001,{pl(4,0),pl(3,2),pl(2,0),pl(1,2)}, 4'b0000,1,1,1,pl(2,0));
    vecs[15] = v(0,0,0,0,0,0,1,4'b0000,D, 4'b0000,0,0,0,0);
    vecs[16] = v(0,0,0,0,0,0,1,4'b0100,{pl(4,0),pl(5,6),pl(2,0),pl(1,0)}, 4'b0100,0,0,0,0);
    vecs[17] = v(0,0,0,0,1,4'b0100,0,4'b0000,D, 4'b0000,0,1,1,pl(5,6));
    vecs[18] = v(0,0,1,4'b0100,0,0,0,4'b0000,D, 4'b0000,0,1,1,pl(5,2));
    vecs[19] = v(0,0,0,0,0,0,0,4'b0000,D, 4'b0000,0,1,1,pl(5,2));
    vecs[20] = v(0,0,0,0,0,0,1,4'b1000,{pl(6,0),pl(3,0),pl(2,0),pl(1,0)}, 4'b1000,0,1,1,pl(5,2));
    vecs[21] = v(0,0,0,0,0,0,1,4'b0010,{pl(6,0),pl(3,0),pl(7,0),pl(1,0)}, 4'b0010,0,1,1,pl(6,0));
    vecs[22] = v(0,1,0,0,0,0,1,4'b0110,{pl(6,0),pl(9,0),pl(8,0),pl(1,0)}, 4'b0000,0,1,1,pl(7,0));
    vecs[23] = v(0,0,0,0,0,0,1,4'b0110,{pl(6,0),pl(9,0),pl(8,0),pl(1,0)}, 4'b0100,0,0,0,0);
    vecs[24] = v(0,0,0,0,0,0,1,4'b0010,{pl(6,0),pl(9,0),pl(8,0),pl(1,0)}, 4'b0010,0,1,1,pl(9,0));
    vecs[25] = v(1,0,0,0,0,0,1,4'b1111,D, 4'b0000,0,1,1,pl(8,0));
    vecs[26] = v(0,0,0,0,0,0,1,4'b1100,D, 4'b0100,0,0,1,0);

    drive(1,0,0,0,0,0,1,4'b1111,D);
    @(posedge clk);

    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      drive(vecs[i].r, vecs[i].f, vecs[i].ke, vecs[i].km, vecs[i].re, vecs[i].rm,
            vecs[i].fu, vecs[i].vld, vecs[i].pay);
      #1;
      check($sformatf("vec%0d grant", i), 32'(req_grant), 32'(vecs[i].eg));
      check($sformatf("vec%0d busy", i), 32'(busy_stall), 32'(vecs[i].eb));
      check($sformatf("vec%0d port_valid", i), 32'(port_valid), 32'(vecs[i].epv));
      if (vecs[i].cps) check($sformatf("vec%0d port_s2e", i), port_s2e, vecs[i].eps);
    end

    // Randomized traffic: requesters hold their payload until granted.
    @(negedge clk);
    drive(1,0,0,0,0,0,1,4'b0000,'0);
    @(posedge clk);
    m_valid = 0; m_pay = '0; m_ptr = 0;
    for (int r = 0; r < N; r++) pend[r] = 0;

    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int r = 0; r < N; r++)
        if (!pend[r] && $urandom_range(1,0) == 1) begin
          pend[r] = 1;
          ppay[r] = {28'($urandom), 4'($urandom)};
        end
      vld_all = '0; pay_all = '0;
      for (int r = 0; r < N; r++) begin
        vld_all[r] = pend[r];
        pay_all[r*PL +: PL] = ppay[r];
      end
      r_r  = ($urandom_range(63,0) == 0);
      f_r  = ($urandom_range(31,0) == 0);
      ke_r = ($urandom_range(7,0) == 0);
      km_r = 4'(1 << $urandom_range(3,0));
      re_r = ($urandom_range(3,0) == 0);
      rm_r = 4'($urandom);
      fu_r = ($urandom_range(3,0) != 0);

      @(negedge clk);
      drive(r_r, f_r, ke_r, km_r, re_r, rm_r, fu_r, vld_all, pay_all);
      #1;

      free = !m_valid || fu_r || is_killed(m_pay, ke_r, km_r);
      win = -1;
      if (!r_r && !f_r && free)
        for (int k = 0; k < N; k++) begin
          int c;
          c = (m_ptr + k) % N;
          if (win < 0 && pend[c] && !is_killed(ppay[c], ke_r, km_r)) win = c;
        end
      eg = (win >= 0) ? 4'(1 << win) : 4'b0000;
      eb = (vld_all != 0) && (win < 0) && !f_r && !r_r;

      check($sformatf("rnd%0d grant", cyc), 32'(req_grant), 32'(eg));
      check($sformatf("rnd%0d busy", cyc), 32'(busy_stall), 32'(eb));
      check($sformatf("rnd%0d port_valid", cyc), 32'(port_valid), 32'(m_valid));
      if (m_valid) check($sformatf("rnd%0d port_s2e", cyc), port_s2e, m_pay);

      if (r_r) begin
        m_valid = 0; m_pay = '0; m_ptr = 0;
      end else if (f_r) begin
        m_valid = 0; m_pay = '0;
      end else if (win >= 0) begin
        np = ppay[win];
        if (re_r) np[3:0] = np[3:0] & ~rm_r;
        m_valid = 1; m_pay = np;
        m_ptr = (win + 1) % N;
        pend[win] = 0;
      end else if (free) begin
        m_valid = 0;
      end else if (re_r) begin
        m_pay[3:0] = m_pay[3:0] & ~rm_r;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ialu_issue_arbiter.md
# ialu_issue_arbiter

Shares one integer-ALU execute port among `NUM_REQ` issue-queue requesters. Each cycle it selects one valid, un-killed requester by rotating round-robin priority and registers that micro-op's S2E payload into a single output stage that drives the ALU's `Port_Valid`/`Port_S2E`. The output stage also filters branch-misprediction kills and pipeline flushes. It clears resolved speculation bits so the held micro-op carries a current kill mask. The block sits between the integer issue queues and the IALU, and adds exactly one pipeline stage on the issue-to-execute path.

## Interface
- `NUM_REQ`, default 4: number of requesters (2..8).
- `PAYLOAD_LEN`, default `` `PORT_S2E_LEN ``: payload width. The kill mask sits at `` `PORT_S2E_KILLMASK `` within the payload.
- `clk`  in  1  clock. All state updates on the rising edge.
- `rst`  in  1  reset. Synchronous, active-high.
- `Flush`  in  1  pipeline flush.
- `Kill_Enable`  in  1  branch-mispredict kill strobe.
- `Kill_VKillMask`  in  `` `SPEC_STATES ``  speculation tags being killed.
- `Resolve_Enable`  in  1  correct-branch resolve strobe.
- `Resolve_Mask`  in  `` `SPEC_STATES ``  speculation tags resolved correct; these bits are cleared from held kill masks.
- `Req_Valid`  in  `NUM_REQ`  per-requester micro-op valid.
- `Req_S2E`  in  `NUM_REQ*PAYLOAD_LEN`  per-requester payloads. Requester i occupies bits `[i*PAYLOAD_LEN +: PAYLOAD_LEN]`.
- `Req_Grant`  out  `NUM_REQ`  one-hot grant. Requester i's micro-op is consumed at this edge.
- `Fu_Ready`  in  1  ALU ready, from the IALU `Ready` output.
- `Port_Valid`  out  1  registered valid to the ALU.
- `Port_S2E`  out  `PAYLOAD_LEN`  registered payload to the ALU.
- `Busy_Stall`  out  1  some requester is valid but none is granted this cycle (performance hook).

## Operation
- **Kill test for requester i:** `ReqKilled[i] = Kill_Enable & |(Req_S2E_i[KILLMASK] & Kill_VKillMask)`.
- **Eligibility:** requester i is eligible when `Req_Valid[i] & ~ReqKilled[i] & ~Flush & ~rst`.
- **Stage free:** `StageFree = ~Port_Valid | Fu_Ready | HeldKilled`. `HeldKilled` is the kill test applied to the held payload.
- **Grant:**
  - When `StageFree`, grant the first eligible requester scanning from `RrPtr`, `RrPtr+1`, … modulo `NUM_REQ`.
  - Otherwise `Req_Grant = 0`.
  - `Req_Grant` is combinational from the current inputs and state. At most one bit is set.
- **Round-robin pointer** (`RrPtr`, `$clog2(NUM_REQ)` bits):
  - On a grant to requester g, the next value is `(g+1) mod NUM_REQ`.
  - With no grant it holds.
  - Reset value is 0. Flush does not alter it.
- **Output stage update**, priority top to bottom:
  1. `rst` or `Flush`: `Port_Valid <= 0`, `Port_S2E <= 0`.
  2. Grant to g: `Port_Valid <= 1`. `Port_S2E <= Req_S2E_g`, with kill-mask bits in `Resolve_Mask` cleared when `Resolve_Enable`.
  3. `StageFree` and no grant: `Port_Valid <= 0`. `Port_S2E` holds (don't-care).
  4. Otherwise (held, not consumed, not killed): `Port_Valid` holds. If `Resolve_Enable`, clear the `Resolve_Mask` bits in the held kill mask.
- **Kill while held:** a killed held micro-op is dropped at the next edge. Its slot is reusable in the same cycle, because `HeldKilled` makes `StageFree` true.
- **Same-cycle kill and resolve of one tag:** kill wins. The kill test uses the pre-clear mask.
- **`Busy_Stall`** = `|Req_Valid & ~|Req_Grant & ~Flush`.

## Timing
- **Reset values:** `Port_Valid=0`, `Port_S2E=0`, `RrPtr=0`, `Req_Grant=0`, `Busy_Stall=0` (`Busy_Stall` is masked while `rst` is high).
- **Latency:** a request granted at edge N appears on `Port_Valid`/`Port_S2E` from edge N through the next edge.
- **Throughput:** one micro-op per cycle while `Fu_Ready=1`.
- **Back-pressure:** with `Fu_Ready=0` the held micro-op stays stable and no grant is issued. A requester must keep `Req_Valid` and its payload stable until granted.
- **Flush:** a flush at edge N clears the stage at edge N. No grant is issued in the flush cycle.
- **Reset mid-operation:** reset discards the held micro-op and restarts priority at requester 0.

## Test plan
- **Reset:** `rst` high 2 cycles with all `Req_Valid=1` -> `Req_Grant=0` and `Port_Valid=0`. In the first cycle after reset, `Req_Grant=0001`.
- **Round-robin fairness:** all 4 valid continuously, `Fu_Ready=1` -> grants cycle 0001, 0010, 0100, 1000, 0001. `Port_S2E` payloads follow one cycle later, with no bubbles.
- **Back-pressure:** `Fu_Ready=0` for 3 cycles with a held micro-op -> `Port_S2E` unchanged, `Req_Grant=0`, `Busy_Stall=1`. When `Fu_Ready` returns to 1, the next requester is granted in that cycle.
- **Kill:**
  - Held micro-op killmask 0010 with `Kill_Enable=1`, `Kill_VKillMask=0010` -> `Port_Valid` drops next edge unless a new eligible requester is granted.
  - A requester with killmask 0010 in the same cycle is never granted.
- **Resolve:** held killmask 0110 with `Resolve_Enable`, `Resolve_Mask=0100` under back-pressure -> held killmask becomes 0010. A later kill on 0100 does not drop it.
- **Flush with grant pending:** `Flush=1` with requester 2 valid and `RrPtr=2` -> no grant, `Port_Valid=0` next cycle. `RrPtr` is still 2 afterwards, so requester 2 is granted first after the flush.
